conv_mac_feeder: RTL and testbench
==================================

Name: conv_mac_feeder

Overview:
Sequencer that drives the input side of the pipelined 14x14->28 MAC and collects its results to compute a 1-D valid convolution y[k] = sum_j x[k+j]*w[j].
- Holds the sample vector x and the tap vector w in local register files.
- For each output k it clears the MAC, streams M operand pairs on the MAC's valid_in interface, waits for M valid_out pulses, and then emits y[k].
- Sits between the host load interface and one MAC instance in the convolution datapath.

Parameters:
N, 16, number of samples in x (N >= M)
M, 4, number of taps in w (M >= 1)
WIDTH, 14, operand width (signed)
ACC_WIDTH, 28, accumulator/result width (signed)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
x_wr_en  input  1  write strobe for the x register file
x_wr_addr  input  $clog2(N)  x write index
x_wr_data  input  WIDTH  signed sample
w_wr_en  input  1  write strobe for the w register file
w_wr_addr  input  $clog2(M)  w write index
w_wr_data  input  WIDTH  signed tap
start  input  1  begin a convolution pass
busy  output  1  pass in progress
done  output  1  one-cycle pulse at end of pass
mac_a  output  WIDTH  operand a to MAC
mac_b  output  WIDTH  operand b to MAC
mac_valid_in  output  1  operand pair valid
mac_clr  output  1  one-cycle synchronous accumulator clear (to MAC reset, ORed with system reset at top level)
mac_valid_out  input  1  MAC result strobe
mac_f  input  ACC_WIDTH  MAC accumulator value
y  output  ACC_WIDTH  convolution result
y_idx  output  $clog2(N)  output index k of y
y_valid  output  1  one-cycle result strobe

Behaviour:
- Clock and reset:
  - One clock, clk. reset is asynchronous and active-high.
  - All outputs, the FSM, counters and both register files reset to 0. FSM resets to IDLE.
- Registered outputs: every output is registered. While mac_valid_in=0, mac_a and mac_b are driven to 0.
- Register file writes:
  - Accepted only in IDLE. Writes while busy=1 are ignored.
  - Reads are combinational from the arrays, into the registered mac_a/mac_b.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, EMIT, FINISH.
- IDLE:
  - busy=0.
  - start=1 -> CLEAR with k=0.
  - start in any other state is ignored.
- CLEAR:
  - mac_clr=1 for exactly one cycle.
  - Reset j=0 and rcv=0.
  - -> ISSUE.
- ISSUE:
  - Each cycle: mac_valid_in=1, mac_a=x[k+j], mac_b=w[j], j++.
  - Exactly M back-to-back cycles, then -> DRAIN.
- rcv counter:
  - Active in ISSUE and DRAIN; increments on each mac_valid_out.
  - In the cycle rcv reaches M, capture mac_f into y and go to EMIT. This may happen in ISSUE only if MAC latency < M; the capture still applies.
  - mac_valid_out outside ISSUE/DRAIN is ignored.
- EMIT:
  - y_valid=1 and y_idx=k for one cycle.
  - k==N-M -> FINISH. Otherwise k++ -> CLEAR.
- FINISH: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Arithmetic:
  - The feeder performs no arithmetic on results. y is mac_f verbatim, including MAC saturation at +/-2^27.
  - Index k+j never exceeds N-1.
- Latency: per output, 1 (CLEAR) + M (ISSUE) + MAC latency + 1 (EMIT). The feeder works for any MAC latency because it counts mac_valid_out and has no latency parameter.
- Totals per pass: exactly N-M+1 y_valid pulses and N-M+1 mac_clr pulses. y_idx is strictly increasing from 0.
- Reset mid-pass: async abort. Outputs drop to 0 immediately and the register files are cleared; a new load is required.
- Degenerate case N==M: exactly one output, y_idx=0.

Decomposition:
- Shared package conv_pkg:
  - FSM state enum.
  - WIDTH/ACC_WIDTH constants.
  - Signed operand and accumulator typedefs.
- One natural sub-module: conv_regfile, a parameterized write-port/combinational-read array instanced for both x and w.

Test Plan:
- N=6, M=3, x=1..6, w=(1,2,3), real MAC, start -> y_valid 4 times: (idx0,14), (idx1,20), (idx2,26), (idx3,32); then done pulse; 4 mac_clr pulses.
- N=4, M=4, all x=w=8191 -> single y=134217727 (MAC positive saturation), y_idx=0.
- x=-8192 everywhere, w=(1,0,0,0), N=5 -> y=-8192 at idx 0 and 1.
- Stub MAC with latency 1 and latency 20 -> identical y sequence; mac_valid_in asserted exactly M consecutive cycles per output.
- start and x_wr_en pulsed during ISSUE -> ignored; results unchanged, x contents unchanged.
- reset asserted mid-ISSUE -> busy, mac_valid_in and mac_a go to 0 without a clock edge; FSM in IDLE; next pass after reload produces correct results.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution MAC feeder.
//   state_t   - sequencer FSM states
//   operand_t - signed MAC operand (CONV_WIDTH bits)
//   acc_t     - signed MAC accumulator/result (CONV_ACC_WIDTH bits)
package conv_pkg;

    localparam int CONV_WIDTH     = 14;
    localparam int CONV_ACC_WIDTH = 28;

    typedef logic signed [CONV_WIDTH-1:0]     operand_t;
    typedef logic signed [CONV_ACC_WIDTH-1:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/conv_regfile.sv
// conv_regfile: single write port, combinational read array.
//   clk, reset        - clock, async active-high reset (clears every entry)
//   wr_en/addr/data   - synchronous write port
//   rd_addr, rd_data  - combinational read port
module conv_regfile #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 14,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv_mac_feeder.sv
// conv_mac_feeder: sequences a pipelined MAC to compute y[k] = sum_j x[k+j]*w[j].
//   clk, reset              - clock, async active-high reset
//   x_wr_*, w_wr_*          - host load ports for samples/taps (IDLE only)
//   start                   - begin a pass (IDLE only)
//   busy, done              - pass in progress / one-cycle end-of-pass pulse
//   mac_a, mac_b            - operands, zero when mac_valid_in=0
//   mac_valid_in, mac_clr   - operand strobe / one-cycle accumulator clear
//   mac_valid_out, mac_f    - MAC result strobe and accumulator value
//   y, y_idx, y_valid       - result, its index k, one-cycle strobe
//
// state  | meaning
// IDLE   | waiting for start, register files writable
// CLEAR  | clear MAC accumulator, reset j and rcv
// ISSUE  | stream M operand pairs x[k+j], w[j]
// DRAIN  | wait until M results have been counted
// EMIT   | present y[k]
// FINISH | pulse done
module conv_mac_feeder
    import conv_pkg::*;
#(
    parameter  int N         = 16,
    parameter  int M         = 4,
    parameter  int WIDTH     = CONV_WIDTH,
    parameter  int ACC_WIDTH = CONV_ACC_WIDTH,
    localparam int AW        = (N > 1) ? $clog2(N) : 1,
    localparam int MW        = (M > 1) ? $clog2(M) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        x_wr_en,
    input  logic [AW-1:0]               x_wr_addr,
    input  logic signed [WIDTH-1:0]     x_wr_data,
    input  logic                        w_wr_en,
    input  logic [MW-1:0]               w_wr_addr,
    input  logic signed [WIDTH-1:0]     w_wr_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic signed [WIDTH-1:0]     mac_a,
    output logic signed [WIDTH-1:0]     mac_b,
    output logic                        mac_valid_in,
    output logic                        mac_clr,
    input  logic                        mac_valid_out,
    input  logic signed [ACC_WIDTH-1:0] mac_f,
    output logic signed [ACC_WIDTH-1:0] y,
    output logic [AW-1:0]               y_idx,
    output logic                        y_valid
);

    localparam int RW = $clog2(M + 1);

    state_t              state, state_nxt;
    logic [AW-1:0]       k;
    logic [MW-1:0]       j;
    logic [RW-1:0]       rcv;
    logic                capture;
    logic                last_issue;
    logic                last_k;
    logic [AW-1:0]       x_rd_addr;
    logic signed [WIDTH-1:0] x_rd, w_rd;

    assign x_rd_addr  = k + AW'(j);
    assign last_issue = (j == MW'(M - 1));
    assign last_k     = (k == AW'(N - M));
    // The M-th result may land while still issuing if the MAC is faster than M cycles.
    assign capture    = ((state == S_ISSUE) || (state == S_DRAIN)) &&
                        mac_valid_out && (rcv == RW'(M - 1));

    conv_regfile #(.DEPTH(N), .WIDTH(WIDTH)) u_x_rf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (x_wr_en && (state == S_IDLE)),
        .wr_addr (x_wr_addr),
        .wr_data (x_wr_data),
        .rd_addr (x_rd_addr),
        .rd_data (x_rd)
    );

    conv_regfile #(.DEPTH(M), .WIDTH(WIDTH)) u_w_rf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en && (state == S_IDLE)),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr (j),
        .rd_data (w_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (capture)         state_nxt = S_EMIT;
                else if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (capture) state_nxt = S_EMIT;
            S_EMIT:   state_nxt = last_k ? S_FINISH : S_CLEAR;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Counters and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k   <= '0;
            j   <= '0;
            rcv <= '0;
            y   <= '0;
        end else begin
            if ((state == S_IDLE) && start) k <= '0;
            if (state == S_CLEAR) begin
                j   <= '0;
                rcv <= '0;
            end
            if ((state == S_ISSUE) && !last_issue) j <= j + 1'b1;
            if (((state == S_ISSUE) || (state == S_DRAIN)) && mac_valid_out)
                rcv <= rcv + 1'b1;
            if (capture) y <= mac_f;
            if ((state == S_EMIT) && !last_k) k <= k + 1'b1;
        end
    end

    // Registered outputs follow the state one cycle later, so mac_clr always
    // precedes the first operand pair of each output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_clr      <= 1'b0;
            y_idx        <= '0;
            y_valid      <= 1'b0;
        end else begin
            busy         <= (state_nxt != S_IDLE);
            done         <= (state == S_FINISH);
            mac_valid_in <= (state == S_ISSUE);
            mac_a        <= (state == S_ISSUE) ? x_rd : '0;
            mac_b        <= (state == S_ISSUE) ? w_rd : '0;
            mac_clr      <= (state == S_CLEAR);
            y_valid      <= (state == S_EMIT);
            if (state == S_EMIT) y_idx <= k;
        end
    end

endmodule

// File: tb/tb_conv_mac_feeder.sv
`timescale 1ns/1ps
module tb_conv_mac_feeder;
    import conv_pkg::*;

    // Three instances: 0 -> N=6,M=3   1 -> N=4,M=4   2 -> N=5,M=4
    int nn [3] = '{6, 4, 5};
    int mm [3] = '{3, 4, 4};

    logic clk = 1'b0;
    logic reset;
    logic [2:0] xwe, wwe, st;
    logic [2:0] xa;
    logic [1:0] wa;
    operand_t   xd, wd;
    logic [2:0] busy, done, mvi, mclr, yv, mvo;
    operand_t   ma [3];
    operand_t   mb [3];
    acc_t       mf [3];
    acc_t       yy [3];
    logic [2:0] yidx_a, yidx_c;
    logic [1:0] yidx_b;
    int         lat [3];

    always #5 clk = ~clk;

    conv_mac_feeder #(.N(6), .M(3)) dut_a (
        .clk(clk), .reset(reset),
        .x_wr_en(xwe[0]), .x_wr_addr(xa), .x_wr_data(xd),
        .w_wr_en(wwe[0]), .w_wr_addr(wa), .w_wr_data(wd),
        .start(st[0]), .busy(busy[0]), .done(done[0]),
        .mac_a(ma[0]), .mac_b(mb[0]), .mac_valid_in(mvi[0]), .mac_clr(mclr[0]),
        .mac_valid_out(mvo[0]), .mac_f(mf[0]),
        .y(yy[0]), .y_idx(yidx_a), .y_valid(yv[0]));

    conv_mac_feeder #(.N(4), .M(4)) dut_b (
        .clk(clk), .reset(reset),
        .x_wr_en(xwe[1]), .x_wr_addr(xa[1:0]), .x_wr_data(xd),
        .w_wr_en(wwe[1]), .w_wr_addr(wa), .w_wr_data(wd),
        .start(st[1]), .busy(busy[1]), .done(done[1]),
        .mac_a(ma[1]), .mac_b(mb[1]), .mac_valid_in(mvi[1]), .mac_clr(mclr[1]),
        .mac_valid_out(mvo[1]), .mac_f(mf[1]),
        .y(yy[1]), .y_idx(yidx_b), .y_valid(yv[1]));

    conv_mac_feeder #(.N(5), .M(4)) dut_c (
        .clk(clk), .reset(reset),
        .x_wr_en(xwe[2]), .x_wr_addr(xa), .x_wr_data(xd),
        .w_wr_en(wwe[2]), .w_wr_addr(wa), .w_wr_data(wd),
        .start(st[2]), .busy(busy[2]), .done(done[2]),
        .mac_a(ma[2]), .mac_b(mb[2]), .mac_valid_in(mvi[2]), .mac_clr(mclr[2]),
        .mac_valid_out(mvo[2]), .mac_f(mf[2]),
        .y(yy[2]), .y_idx(yidx_c), .y_valid(yv[2]));

    // ---------------- MAC model: saturating accumulate, variable latency
    function automatic acc_t sat(longint s);
        if (s > 134217727)       return 28'sh7FFFFFF;
        else if (s < -134217728) return 28'sh8000000;
        else                     return s[27:0];
    endfunction

    acc_t acc [3];
    logic pv  [3][32];
    acc_t pd  [3][32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < 3; g++) begin
                acc[g] <= '0;
                for (int i = 0; i < 32; i++) begin
                    pv[g][i] <= 1'b0;
                    pd[g][i] <= '0;
                end
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (mclr[g]) begin
                    acc[g] <= '0;
                    for (int i = 0; i < 32; i++) begin
                        pv[g][i] <= 1'b0;
                        pd[g][i] <= '0;
                    end
                end else begin
                    pv[g][0] <= mvi[g];
                    pd[g][0] <= mvi[g] ? sat(longint'(acc[g]) + longint'(ma[g]) * longint'(mb[g])) : acc[g];
                    if (mvi[g]) acc[g] <= sat(longint'(acc[g]) + longint'(ma[g]) * longint'(mb[g]));
                    for (int i = 1; i < 32; i++) begin
                        pv[g][i] <= pv[g][i-1];
                        pd[g][i] <= pd[g][i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        mvo = '0;
        for (int g = 0; g < 3; g++) begin
            mvo[g] = pv[g][lat[g]-1];
            mf[g]  = pd[g][lat[g]-1];
        end
    end

    // ---------------- scoreboard
    typedef struct {
        int     g;
        int     idx;
        longint val;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int run [3];
    int clr_cnt [3];
    int done_cnt [3];
    int d0s [3];
    int c0s [3];

    task automatic check(string name, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int yi(int g);
        case (g)
            0:       return int'(yidx_a);
            1:       return int'(yidx_b);
            default: return int'(yidx_c);
        endcase
    endfunction

    task automatic expect_y(int g, int idx, longint val);
        exp_t e;
        e.g = g; e.idx = idx; e.val = val;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int g = 0; g < 3; g++) run[g] = 0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (yv[g]) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_y: dut %0d idx %0d y %0d, expected none", g, yi(g), yy[g]);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("y_dut", g, e.g);
                        check("y_idx", yi(g), e.idx);
                        check("y_val", longint'(yy[g]), e.val);
                    end
                end
                if (mvi[g]) run[g]++;
                else if (run[g] != 0) begin
                    check("issue_run_len", run[g], mm[g]);
                    check("mac_a_idle_zero", longint'(ma[g]), 0);
                    run[g] = 0;
                end
                if (mclr[g]) clr_cnt[g]++;
                if (done[g]) done_cnt[g]++;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic wr_x(int g, int a, int d);
        @(negedge clk);
        xa = a[2:0]; xd = d[13:0]; xwe[g] = 1'b1;
        @(negedge clk);
        xwe[g] = 1'b0;
    endtask

    task automatic wr_w(int g, int a, int d);
        @(negedge clk);
        wa = a[1:0]; wd = d[13:0]; wwe[g] = 1'b1;
        @(negedge clk);
        wwe[g] = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < 6; i++) wr_x(0, i, i + 1);
        for (int i = 0; i < 3; i++) wr_w(0, i, i + 1);
    endtask

    task automatic start_pass(int g);
        d0s[g] = done_cnt[g];
        c0s[g] = clr_cnt[g];
        @(negedge clk);
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
    endtask

    task automatic finish_pass(int g);
        for (int c = 0; c < 3000 && done_cnt[g] == d0s[g]; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("done_pulses", done_cnt[g] - d0s[g], 1);
        check("mac_clr_pulses", clr_cnt[g] - c0s[g], nn[g] - mm[g] + 1);
        check("scoreboard_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic expect_a_ref();
        expect_y(0, 0, 14); expect_y(0, 1, 20); expect_y(0, 2, 26); expect_y(0, 3, 32);
    endtask

    task automatic wait_issue(int g);
        int c;
        c = 0;
        while (!mvi[g] && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("reached_issue", mvi[g], 1);
    endtask

    initial begin
        xwe = '0; wwe = '0; st = '0; xa = '0; wa = '0; xd = '0; wd = '0;
        lat = '{3, 3, 3};
        for (int g = 0; g < 3; g++) begin
            run[g] = 0; clr_cnt[g] = 0; done_cnt[g] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y_valid", yv, 0);
        check("rst_mac_valid_in", mvi, 0);
        check("rst_mac_clr", mclr, 0);
        check("rst_mac_a", longint'(ma[0]), 0);
        check("rst_y", longint'(yy[0]), 0);
        reset = 1'b0;

        load_a();
        for (int i = 0; i < 4; i++) wr_x(1, i, 8191);
        for (int i = 0; i < 4; i++) wr_w(1, i, 8191);
        for (int i = 0; i < 5; i++) wr_x(2, i, -8192);
        for (int i = 0; i < 4; i++) wr_w(2, i, (i == 0) ? 1 : 0);

        // basic pass, then MAC latency 1 and 20 must give the same sequence
        expect_a_ref(); start_pass(0); finish_pass(0);
        lat[0] = 1;
        expect_a_ref(); start_pass(0); finish_pass(0);
        lat[0] = 20;
        expect_a_ref(); start_pass(0); finish_pass(0);
        lat[0] = 3;

        // N==M with positive saturation
        expect_y(1, 0, 134217727); start_pass(1); finish_pass(1);
        // most negative operand
        expect_y(2, 0, -8192); expect_y(2, 1, -8192); start_pass(2); finish_pass(2);

        // start and x write during ISSUE are ignored
        expect_a_ref();
        start_pass(0);
        wait_issue(0);
        @(negedge clk);
        st[0] = 1'b1; xa = 3'd0; xd = 14'sd100; xwe[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; xwe[0] = 1'b0;
        finish_pass(0);
        expect_a_ref(); start_pass(0); finish_pass(0);

        // asynchronous reset mid-ISSUE
        start_pass(0);
        wait_issue(0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", busy[0], 0);
        check("async_rst_mac_valid_in", mvi[0], 0);
        check("async_rst_mac_a", longint'(ma[0]), 0);
        check("async_rst_state_idle", dut_a.state, S_IDLE);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        // register files were cleared: results are all zero
        for (int k = 0; k < 4; k++) expect_y(0, k, 0);
        start_pass(0); finish_pass(0);
        load_a();
        expect_a_ref(); start_pass(0); finish_pass(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
